// File: rtl/chrono_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chrono_pkg
// Description : Shared types and helpers for the lap chronometer.
// Revision    : 1.0 - initial release
// ============================================================================
package chrono_pkg;

    localparam int c_default_tick_div = 5000000;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_WR   = 2'd1,
        M_RD   = 2'd2
    } mem_state_e;

    // One packed-BCD digit step; returns {carry_out, digit_out}.
    function automatic logic [4:0] bcd_digit_inc(input logic [3:0] digit, input logic carry_in);
        logic [4:0] res;
        res = {1'b0, digit};
        if (carry_in) begin
            if (digit >= 4'd9) begin
                res = {1'b1, 4'd0};
            end else begin
                res = {1'b0, digit + 4'd1};
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/chrono_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : chrono_prescaler
// Description : Divides clk down to a one-cycle count tick every TICK_DIV
//               enabled cycles; holds its phase while disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module chrono_prescaler
    import chrono_pkg::*;
#(
    parameter int TICK_DIV = c_default_tick_div
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int              c_cw   = $clog2(TICK_DIV);
    localparam logic [c_cw-1:0] c_term = c_cw'(TICK_DIV - 1);

    logic [c_cw-1:0] r_cnt;

    assign tick = enable && (r_cnt == c_term);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= tick ? '0 : r_cnt + c_cw'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/lap_chronometer.sv
`default_nettype none
// ============================================================================
// Module      : lap_chronometer
// Description : Stopwatch with lap storage/replay through an external word
//               memory. Define CHRONO_BCD_EN for a packed-BCD count.
// Revision    : 1.0 - initial release
// ============================================================================
module lap_chronometer
    import chrono_pkg::*;
#(
    parameter int TICK_DIV  = c_default_tick_div,
    parameter int DATA_SIZE = 16,
    parameter int ADDR_SIZE = 4,
    parameter int LAP_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 restart,
    input  logic                 lap,
    input  logic                 recall,
    output logic [ADDR_SIZE-1:0] wr_addr,
    output logic [DATA_SIZE-1:0] wr_data,
    output logic                 wr_en,
    output logic [ADDR_SIZE-1:0] rd_addr,
    output logic                 rd_en,
    input  logic [DATA_SIZE-1:0] rd_data,
    input  logic                 rd_done,
    output logic                 cs,
    output logic [DATA_SIZE-1:0] value,
    output logic [ADDR_SIZE:0]   lap_count,
    output logic                 running,
    output logic                 busy
);

    localparam logic [ADDR_SIZE-1:0] c_last_slot = ADDR_SIZE'(LAP_DEPTH - 1);
    localparam logic [ADDR_SIZE:0]   c_depth     = (ADDR_SIZE + 1)'(LAP_DEPTH);

    logic                 r_running;
    logic [DATA_SIZE-1:0] r_count;
    logic [DATA_SIZE-1:0] w_count_next;
    logic                 w_run_en;
    logic                 w_tick;

    mem_state_e           r_state;
    logic                 r_wr_en;
    logic                 r_rd_en;
    logic [ADDR_SIZE-1:0] r_wr_addr;
    logic [DATA_SIZE-1:0] r_wr_data;
    logic [ADDR_SIZE-1:0] r_rd_addr;
    logic [ADDR_SIZE-1:0] r_wr_ptr;
    logic [ADDR_SIZE-1:0] r_rd_idx;
    logic [ADDR_SIZE:0]   r_lap_count;
    logic                 r_show_lap;
    logic [DATA_SIZE-1:0] r_lap_reg;

    // A stop pulse freezes the prescaler on its own edge so resume keeps the phase.
    assign w_run_en = r_running & ~stop;

    chrono_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .enable (w_run_en),
        .clear  (restart),
        .tick   (w_tick)
    );

`ifdef CHRONO_BCD_EN
    always_comb begin
        logic       carry;
        logic [4:0] step;
        carry        = 1'b1;
        step         = '0;
        w_count_next = r_count;
        for (int i = 0; i < DATA_SIZE / 4; i++) begin
            step                  = bcd_digit_inc(r_count[i*4 +: 4], carry);
            w_count_next[i*4 +: 4] = step[3:0];
            carry                 = step[4];
        end
    end
`else
    assign w_count_next = r_count + DATA_SIZE'(1);
`endif

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_running <= 1'b0;
            r_count   <= '0;
        end else begin
            if (stop) begin
                r_running <= 1'b0;
            end else if (start) begin
                r_running <= 1'b1;
            end
            if (w_tick) begin
                r_count <= w_count_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_state     <= M_IDLE;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_rd_addr   <= '0;
            r_wr_ptr    <= '0;
            r_rd_idx    <= '0;
            r_lap_count <= '0;
            r_show_lap  <= 1'b0;
            r_lap_reg   <= '0;
        end else begin
            if (start) begin
                r_show_lap <= 1'b0;
            end
            case (r_state)
                M_IDLE: begin
                    if (lap) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_wr_ptr;
                        r_wr_data <= r_count;
                        r_state   <= M_WR;
                    end else if (recall && (r_lap_count != '0)) begin
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= r_rd_idx;
                        r_state   <= M_RD;
                    end
                end
                M_WR: begin
                    r_wr_en  <= 1'b0;
                    r_wr_ptr <= (r_wr_ptr == c_last_slot) ? '0 : r_wr_ptr + ADDR_SIZE'(1);
                    if (r_lap_count != c_depth) begin
                        r_lap_count <= r_lap_count + (ADDR_SIZE + 1)'(1);
                    end
                    r_state <= M_IDLE;
                end
                M_RD: begin
                    if (rd_done) begin
                        r_rd_en    <= 1'b0;
                        r_lap_reg  <= rd_data;
                        r_show_lap <= 1'b1;
                        // Replay wraps over the laps actually stored, not the full depth.
                        r_rd_idx   <= (({1'b0, r_rd_idx} + (ADDR_SIZE + 1)'(1)) == r_lap_count)
                                      ? '0 : r_rd_idx + ADDR_SIZE'(1);
                        r_state    <= M_IDLE;
                    end
                end
                default: begin
                    r_wr_en <= 1'b0;
                    r_rd_en <= 1'b0;
                    r_state <= M_IDLE;
                end
            endcase
        end
    end

    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign wr_en     = r_wr_en;
    assign rd_addr   = r_rd_addr;
    assign rd_en     = r_rd_en;
    assign cs        = r_wr_en | r_rd_en;
    assign value     = r_show_lap ? r_lap_reg : r_count;
    assign lap_count = r_lap_count;
    assign running   = r_running;
    assign busy      = (r_state != M_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_lap_chronometer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lap_chronometer
// Description : Directed self-checking bench for lap_chronometer (TICK_DIV=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lap_chronometer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stop = 1'b0, restart = 1'b0, lap = 1'b0, recall = 1'b0;
    logic [3:0]  wr_addr, rd_addr;
    logic [15:0] wr_data, value;
    logic [15:0] rd_data = '0;
    logic        rd_done = 1'b0;
    logic        wr_en, rd_en, cs, running, busy;
    logic [4:0]  lap_count;

    logic [15:0] mem [0:15];
    int checks = 0;
    int errors = 0;

    lap_chronometer #(
        .TICK_DIV  (4),
        .DATA_SIZE (16),
        .ADDR_SIZE (4),
        .LAP_DEPTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .restart   (restart),
        .lap       (lap),
        .recall    (recall),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .rd_addr   (rd_addr),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_done   (rd_done),
        .cs        (cs),
        .value     (value),
        .lap_count (lap_count),
        .running   (running),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // External lap RAM
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    function automatic logic [15:0] disp(input int n);
`ifdef CHRONO_BCD_EN
        disp = {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
`else
        disp = 16'(n);
`endif
    endfunction

    // Presents pulses for exactly one posedge; starts and ends on a negedge.
    task automatic drive(input logic s_start, input logic s_stop, input logic s_restart,
                         input logic s_lap, input logic s_recall);
        start = s_start; stop = s_stop; restart = s_restart; lap = s_lap; recall = s_recall;
        @(negedge clk);
        start = 1'b0; stop = 1'b0; restart = 1'b0; lap = 1'b0; recall = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        checks++; if (value !== 16'd0) begin errors++; $display("FAIL reset_value: got %0h want 0", value); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %0b want 0", running); end
        checks++; if (lap_count !== 5'd0) begin errors++; $display("FAIL reset_lap_count: got %0d want 0", lap_count); end
        checks++; if ({wr_en, rd_en, cs, busy} !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %b want 0000", {wr_en, rd_en, cs, busy}); end
    endtask

    task automatic test_count;
        drive(1, 0, 0, 0, 0);
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_running: got %0b want 1", running); end
        wait_cycles(3);
        checks++; if (value !== disp(0)) begin errors++; $display("FAIL first_tick_early: got %0h want %0h", value, disp(0)); end
        wait_cycles(1);
        checks++; if (value !== disp(1)) begin errors++; $display("FAIL first_tick: got %0h want %0h", value, disp(1)); end
        wait_cycles(35);
        checks++; if (value !== disp(9)) begin errors++; $display("FAIL count_39: got %0h want %0h", value, disp(9)); end
        wait_cycles(1);
        checks++; if (value !== disp(10)) begin errors++; $display("FAIL count_40: got %0h want %0h", value, disp(10)); end
        wait_cycles(2);
        drive(0, 1, 0, 0, 0);
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL stop_running: got %0b want 0", running); end
        wait_cycles(20);
        checks++; if (value !== disp(10)) begin errors++; $display("FAIL stop_hold: got %0h want %0h", value, disp(10)); end
        drive(1, 0, 0, 0, 0);
        wait_cycles(1);
        checks++; if (value !== disp(10)) begin errors++; $display("FAIL resume_early: got %0h want %0h", value, disp(10)); end
        wait_cycles(1);
        checks++; if (value !== disp(11)) begin errors++; $display("FAIL resume_tick: got %0h want %0h", value, disp(11)); end
    endtask

    task automatic test_lap;
        drive(0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0);
        wait_cycles(12);
        checks++; if (value !== disp(3)) begin errors++; $display("FAIL lap_pre3: got %0h want %0h", value, disp(3)); end
        drive(0, 0, 0, 1, 0);
        checks++; if ({wr_en, cs, busy} !== 3'b111) begin errors++; $display("FAIL lap1_strobe: got %b want 111", {wr_en, cs, busy}); end
        checks++; if (wr_addr !== 4'd0 || wr_data !== disp(3)) begin errors++; $display("FAIL lap1_write: got addr %0d data %0h want 0 %0h", wr_addr, wr_data, disp(3)); end
        checks++; if (lap_count !== 5'd0) begin errors++; $display("FAIL lap1_count_early: got %0d want 0", lap_count); end
        wait_cycles(1);
        checks++; if (wr_en !== 1'b0 || lap_count !== 5'd1) begin errors++; $display("FAIL lap1_done: got wr_en %0b count %0d want 0 1", wr_en, lap_count); end
        wait_cycles(14);
        drive(0, 0, 0, 1, 0);
        checks++; if (wr_en !== 1'b1 || wr_addr !== 4'd1 || wr_data !== disp(7)) begin errors++; $display("FAIL lap2_write: got en %0b addr %0d data %0h want 1 1 %0h", wr_en, wr_addr, wr_data, disp(7)); end
        wait_cycles(1);
        checks++; if (lap_count !== 5'd2) begin errors++; $display("FAIL lap2_count: got %0d want 2", lap_count); end
    endtask

    task automatic recall_once(input int lat, input logic inject_lap,
                               input logic [3:0] exp_addr, input logic [15:0] exp_val);
        drive(0, 0, 0, 0, 1);
        checks++; if (rd_en !== 1'b1 || cs !== 1'b1 || rd_addr !== exp_addr) begin errors++; $display("FAIL recall_req: got en %0b cs %0b addr %0d want 1 1 %0d", rd_en, cs, rd_addr, exp_addr); end
        for (int i = 0; i < lat; i++) begin
            lap = inject_lap && (i == 0);
            @(negedge clk);
            lap = 1'b0;
            checks++; if (rd_en !== 1'b1) begin errors++; $display("FAIL recall_hold: got %0b want 1", rd_en); end
        end
        rd_done = 1'b1;
        rd_data = mem[rd_addr];
        @(negedge clk);
        rd_done = 1'b0;
        rd_data = '0;
        checks++; if (rd_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL recall_release: got en %0b busy %0b want 0 0", rd_en, busy); end
        checks++; if (value !== exp_val) begin errors++; $display("FAIL recall_value: got %0h want %0h", value, exp_val); end
    endtask

    task automatic test_recall;
        drive(0, 1, 0, 0, 0);
        checks++; if (value !== disp(7)) begin errors++; $display("FAIL recall_stop: got %0h want %0h", value, disp(7)); end
        recall_once(2, 1'b1, 4'd0, disp(3));
        recall_once(2, 1'b0, 4'd1, disp(7));
        recall_once(2, 1'b0, 4'd0, disp(3));
        recall_once(0, 1'b0, 4'd1, disp(7));
        recall_once(1, 1'b0, 4'd0, disp(3));
        checks++; if (lap_count !== 5'd2) begin errors++; $display("FAIL lap_while_busy: got %0d want 2", lap_count); end
        drive(1, 0, 0, 0, 0);
        checks++; if (value !== disp(7)) begin errors++; $display("FAIL start_live: got %0h want %0h", value, disp(7)); end
    endtask

    task automatic test_full;
        drive(0, 0, 1, 0, 0);
        lap = 1'b1;
        wait_cycles(2);
        lap = 1'b0;
        checks++; if (lap_count !== 5'd1) begin errors++; $display("FAIL lap_held_two: got %0d want 1", lap_count); end
        for (int k = 2; k <= 18; k++) begin
            drive(0, 0, 0, 1, 0);
            checks++; if (wr_en !== 1'b1 || wr_addr !== 4'((k - 1) % 16)) begin errors++; $display("FAIL full_slot%0d: got en %0b addr %0d want 1 %0d", k, wr_en, wr_addr, (k - 1) % 16); end
            wait_cycles(1);
            checks++; if (lap_count !== 5'((k > 16) ? 16 : k)) begin errors++; $display("FAIL full_count%0d: got %0d want %0d", k, lap_count, (k > 16) ? 16 : k); end
        end
    endtask

    task automatic test_restart;
        drive(1, 0, 0, 0, 0);
        wait_cycles(3);
        drive(0, 0, 0, 1, 0);
        checks++; if (wr_data !== disp(0) || wr_addr !== 4'd2 || value !== disp(1)) begin errors++; $display("FAIL lap_on_tick: got data %0h addr %0d value %0h want %0h 2 %0h", wr_data, wr_addr, value, disp(0), disp(1)); end
        wait_cycles(4);
        checks++; if (value !== disp(2) || lap_count !== 5'd16) begin errors++; $display("FAIL pre_restart: got value %0h count %0d want %0h 16", value, lap_count, disp(2)); end
        drive(1, 0, 1, 0, 0);
        checks++; if (running !== 1'b0 || value !== 16'd0 || lap_count !== 5'd0) begin errors++; $display("FAIL restart_start: got run %0b value %0h count %0d want 0 0 0", running, value, lap_count); end
        drive(1, 1, 0, 0, 0);
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL stop_over_start: got %0b want 0", running); end
        drive(0, 0, 0, 0, 1);
        checks++; if (rd_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL recall_empty: got en %0b busy %0b want 0 0", rd_en, busy); end
        drive(0, 0, 0, 1, 0);
        wait_cycles(1);
        drive(0, 0, 0, 0, 1);
        checks++; if (rd_en !== 1'b1) begin errors++; $display("FAIL abort_req: got %0b want 1", rd_en); end
        wait_cycles(1);
        drive(0, 0, 1, 0, 0);
        checks++; if (rd_en !== 1'b0 || busy !== 1'b0 || lap_count !== 5'd0) begin errors++; $display("FAIL abort_read: got en %0b busy %0b count %0d want 0 0 0", rd_en, busy, lap_count); end
        rd_done = 1'b1;
        rd_data = 16'hBEEF;
        @(negedge clk);
        rd_done = 1'b0;
        rd_data = '0;
        checks++; if (value !== 16'd0 || rd_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL late_done: got value %0h en %0b busy %0b want 0 0 0", value, rd_en, busy); end
    endtask

`ifdef CHRONO_BCD_EN
    task automatic test_bcd;
        drive(0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0);
        wait_cycles(4 * 99);
        checks++; if (value !== 16'h0099) begin errors++; $display("FAIL bcd_99: got %0h want 0099", value); end
        wait_cycles(4);
        checks++; if (value !== 16'h0100) begin errors++; $display("FAIL bcd_100: got %0h want 0100", value); end
        wait_cycles(4 * 9999 - 400);
        checks++; if (value !== 16'h9999) begin errors++; $display("FAIL bcd_9999: got %0h want 9999", value); end
        wait_cycles(4);
        checks++; if (value !== 16'h0000) begin errors++; $display("FAIL bcd_wrap: got %0h want 0000", value); end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset;
        test_count;
        test_lap;
        test_recall;
        test_full;
        test_restart;
`ifdef CHRONO_BCD_EN
        test_bcd;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/lap_chronometer.md
# lap_chronometer

Parametrised stopwatch core with lap memory: counts display units from a programmable prescaler and stores lap times into an external word memory. It replays stored laps through the same memory port, using the rd_done handshake. It sits between the debounced button front end and the shared lap RAM/display path, replacing the single-value chronometer control.

## Interface

- TICK_DIV, 5000000: clk cycles per count increment (≥2)
- DATA_SIZE, 16: count/lap word width
- ADDR_SIZE, 4: memory address width
- LAP_DEPTH, 16: lap slots used (2..2**ADDR_SIZE)
- clk  in  1  system clock; one clock domain
- rst  in  1  synchronous, active-high reset
- start / stop / restart / lap / recall  in  1 each  single-cycle pulses, already debounced
- wr_addr  out  ADDR_SIZE  lap write slot
- wr_data  out  DATA_SIZE  lap value
- wr_en  out  1  one-cycle write strobe
- rd_addr  out  ADDR_SIZE  lap read slot
- rd_en  out  1  read request, held until rd_done
- rd_data  in  DATA_SIZE  read data, valid when rd_done=1
- rd_done  in  1  read completion
- cs  out  1  memory select, =wr_en|rd_en
- value  out  DATA_SIZE  live count, or recalled lap while show_lap=1
- lap_count  out  ADDR_SIZE+1  stored laps, saturates at LAP_DEPTH
- running  out  1  count enabled
- busy  out  1  memory FSM not in M_IDLE

## Operation

- Reset: count, prescaler, wr_ptr, rd_idx and lap_count go to 0; running, show_lap and all strobes go to 0; cs=0.
- Run control:
  - start sets running.
  - stop clears running and freezes the prescaler (resume continues mid-period).
  - restart zeroes count, prescaler, pointers and lap_count, clears running and show_lap, and forces the memory FSM to M_IDLE. An in-flight read is aborted, and any late rd_done is ignored.
- Priority in one cycle: restart > stop > start. lap and recall are evaluated after run control in the same cycle.
- Count: when running, prescaler counts 0..TICK_DIV-1. At terminal value the prescaler returns to 0 and count increments. Count wraps from max (all ones) to 0.
- Memory FSM states:
  - M_IDLE: lap → M_WR. recall with lap_count>0 → M_RD. If lap and recall arrive together, lap wins and recall is dropped.
  - M_WR: wr_en=1, wr_addr=wr_ptr, wr_data=count sampled on the lap cycle. wr_ptr advances mod LAP_DEPTH, and lap_count increments (saturating). Returns to M_IDLE.
  - M_RD: rd_en=1 and rd_addr=rd_idx, held until rd_done. On rd_done, rd_data is latched to lap_reg, show_lap is set, rd_idx advances mod lap_count, and the FSM returns to M_IDLE.
- lap and recall pulses arriving while busy=1 are dropped.
- lap is accepted whether running or stopped. recall with lap_count=0 is ignored.
- Full buffer: once full, laps overwrite the oldest slot in circular order and lap_count stays at LAP_DEPTH.
- Counting continues during M_WR and M_RD.
- show_lap is cleared by start or restart. value = show_lap ? lap_reg : count.

## Timing

- Pulse at edge t is acted on at edge t; outputs change after t.
- start: running=1 from t+1. First increment comes TICK_DIV cycles after start.
- lap: wr_en/cs high for exactly one cycle, t+1. wr_data is the count at t, pre-increment if a tick coincides. lap_count updates at t+2.
- recall: rd_en high from t+1 through the cycle where rd_done=1.
  - rd_done may arrive in the same cycle as rd_en, giving a minimum of 1 cycle.
  - value shows the lap in the cycle after rd_done. rd_en is low that cycle.
- Restart mid-read: rd_en low the cycle after restart.

## Configuration

- CHRONO_BCD_EN defined: count is packed BCD, DATA_SIZE/4 digits (DATA_SIZE must be a multiple of 4). Each digit rolls over 9→0 with carry, and the count wraps from all-9s to 0 (e.g. 9999→0000 at 16 bits).
- CHRONO_BCD_EN undefined: plain binary count, wrapping from 2**DATA_SIZE-1 to 0.
- Memory behaviour is identical in both builds.

## Structure

- Package chrono_pkg holds:
  - the memory FSM enum (M_IDLE, M_WR, M_RD)
  - the BCD increment function
  - the default TICK_DIV constant
- Sub-module chrono_prescaler (TICK_DIV parameter; enable and clear inputs; tick output) generates the count tick. Everything else stays in lap_chronometer.

## Test plan

- TICK_DIV=4, start, run 40 cycles → count=10; stop, wait 20 cycles → count stays 10; start → first increment after the remaining prescaler period.
- Lap at count=3, then at count=7 → wr_en at slots 0 and 1 with data 3 and 7; lap_count=2.
- 18 laps with LAP_DEPTH=16 → slots 0,1 overwritten by laps 17,18; lap_count=16.
- Recall ×3 with 2 laps and rd_done 2 cycles after rd_en → value shows 3, 7, 3. rd_en is held until rd_done each time. start returns value to the live count.
- restart and start in the same cycle, plus restart mid-read → running=0, count=0, lap_count=0, rd_en low next cycle, late rd_done ignored.
- With CHRONO_BCD_EN: run from 0x0099 → 0x0100; from 0x9999 → 0x0000.
